// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller and the ALU: state codes,
// opcode/funct fields, ALU operations and datapath mux selects.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  // Which source decides the ALU operation in the current state.
  typedef enum logic [1:0] {
    ClsAdd   = 2'd0,
    ClsFunct = 2'd1,
    ClsBeq   = 2'd2
  } alu_cls_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;
  localparam logic [2:0] AluBeq = 3'b100;

  localparam logic [1:0] SrcbRegB  = 2'b00;
  localparam logic [1:0] SrcbFour  = 2'b01;
  localparam logic [1:0] SrcbImm   = 2'b10;
  localparam logic [1:0] SrcbImmSh = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU operation decoder.
//   funct       in  : instr[5:0]
//   cls         in  : state class (alu_cls_e) selecting add / funct / beq-compare
//   aluop       out : ALU operation
//   funct_legal out : funct is one of the supported R-type functions
module alu_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] cls,
  output logic [2:0] aluop,
  output logic       funct_legal
);

  logic [2:0] funct_op;

  always_comb begin
    funct_op    = AluAdd;
    funct_legal = 1'b0;
    unique case (funct)
      FnAdd: begin funct_op = AluAdd; funct_legal = 1'b1; end
      FnSub: begin funct_op = AluSub; funct_legal = 1'b1; end
      FnAnd: begin funct_op = AluAnd; funct_legal = 1'b1; end
      FnOr:  begin funct_op = AluOr;  funct_legal = 1'b1; end
      FnSlt: begin funct_op = AluSlt; funct_legal = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    aluop = AluAdd;
    case (cls)
      ClsFunct: aluop = funct_op;
      ClsBeq:   aluop = AluBeq;
      default:  aluop = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM (lw, sw, R-type, beq, addi, j).
//   clk, reset        : clock, synchronous active-high reset
//   opcode, funct     : instruction fields from the instruction register
//   zero              : ALU compare flag, used only for pcen in BRANCH
//   aluop, alusrca, alusrcb, iord, memwrite, irwrite, regdst, memtoreg,
//   regwrite, pcsrc, pcen : Moore-decoded datapath controls
//   state             : current state code for debug
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] aluop,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [3:0] state
);

  // Plain 4-bit register so the unused codes 12-15 stay representable.
  logic [3:0] state_q, state_d;
  logic [1:0] alu_cls;
  logic [2:0] dec_aluop;
  logic       funct_legal;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    alu_cls = ClsAdd;
    case (state_q)
      StExec:   alu_cls = ClsFunct;
      StBranch: alu_cls = ClsBeq;
      default:  alu_cls = ClsAdd;
    endcase
  end

  alu_dec u_alu_dec (
    .funct       (funct),
    .cls         (alu_cls),
    .aluop       (dec_aluop),
    .funct_legal (funct_legal)
  );

  always_comb begin
    state_d  = StFetch;
    aluop    = dec_aluop;
    alusrca  = 1'b0;
    alusrcb  = SrcbRegB;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    pcsrc    = PcAlu;
    pcen     = 1'b0;
    state    = state_q;

    case (state_q)
      StFetch: begin
        irwrite = 1'b1;
        alusrcb = SrcbFour;
        pcen    = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        alusrcb = SrcbImmSh;
        case (opcode)
          OpRtype:    state_d = StExec;
          OpLw, OpSw: state_d = StMemAdr;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;  // unknown opcode executes as a nop
        endcase
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = SrcbImm;
        state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        iord    = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      StMemWr: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      StExec: begin
        alusrca = 1'b1;
        state_d = StAluWb;
      end
      StAluWb: begin
        regdst   = 1'b1;
        regwrite = funct_legal;  // unsupported funct must not corrupt the register file
      end
      StBranch: begin
        alusrca = 1'b1;
        pcsrc   = PcAluOut;
        pcen    = zero;
      end
      StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = SrcbImm;
        state_d = StAddiWb;
      end
      StAddiWb: regwrite = 1'b1;
      StJump: begin
        pcsrc = PcJump;
        pcen  = 1'b1;
      end
      default: state_d = StFetch;
    endcase

    // Reset masks every strobe immediately so an aborted instruction never commits.
    if (reset) begin
      aluop    = AluAdd;
      alusrca  = 1'b0;
      alusrcb  = SrcbRegB;
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      pcsrc    = PcAlu;
      pcen     = 1'b0;
      state    = StFetch;
    end
  end

endmodule
